// File: rtl/nco_voice_scheduler_if.sv
// Start/done handshake between the voice scheduler and the shared NCO interpolation core.
// The master side issues phases and the slave side (the core) returns samples.
interface nco_voice_scheduler_if #(
  parameter int unsigned ACC_W    = 32,
  parameter int unsigned SAMPLE_W = 16
);
  logic                       core_start;
  logic [ACC_W-1:0]           core_phase;
  logic                       core_done;
  logic signed [SAMPLE_W-1:0] core_sample;

  modport master (
    output core_start,
    output core_phase,
    input  core_done,
    input  core_sample
  );

  modport slave (
    input  core_start,
    input  core_phase,
    output core_done,
    output core_sample
  );
endinterface

// File: rtl/nco_voice_scheduler.sv
// Shares one stateless NCO core across NUM_VOICES phase accumulators, one frame per
// sample_clk_en, and mixes the returned samples into a saturated output.
module nco_voice_scheduler #(
  parameter int unsigned NUM_VOICES = 4,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned SAMPLE_W   = 16
) (
  input  logic                          master_clk,
  input  logic                          rst,
  input  logic                          sample_clk_en,
  input  logic [NUM_VOICES-1:0]         voice_enable,
  input  logic [NUM_VOICES*ACC_W-1:0]   voice_increment,
  nco_voice_scheduler_if.master         core,
  output logic signed [SAMPLE_W-1:0]    mix_output,
  output logic                          mix_valid,
  output logic                          sample_overrun,
  output logic                          busy
);

  localparam int unsigned VoiceW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int unsigned SumW   = SAMPLE_W + $clog2(NUM_VOICES) + 1;
  localparam logic signed [SumW-1:0] SumMax = SumW'((64'sd1 <<< (SAMPLE_W - 1)) - 64'sd1);
  localparam logic signed [SumW-1:0] SumMin = SumW'(-(64'sd1 <<< (SAMPLE_W - 1)));

  typedef enum logic [2:0] {StIdle, StAdvance, StDispatch, StWait, StOutput} state_e;

  state_e                     state_q, state_d;
  logic [NUM_VOICES-1:0]      en_q, en_d;
  logic [ACC_W-1:0]           phase_q [NUM_VOICES];
  logic [ACC_W-1:0]           phase_d [NUM_VOICES];
  logic [VoiceW-1:0]          voice_q, voice_d;
  logic signed [SumW-1:0]     sum_q, sum_d;
  logic signed [SumW-1:0]     sample_ext;
  logic signed [SAMPLE_W-1:0] sat;
  logic                       last_voice;
  logic                       start_d;

  logic                       core_start_q;
  logic [ACC_W-1:0]           core_phase_q;
  logic signed [SAMPLE_W-1:0] mix_output_q;
  logic                       mix_valid_q;
  logic                       overrun_q;
  logic                       busy_q;

  assign last_voice = (voice_q == VoiceW'(NUM_VOICES - 1));
  assign sample_ext = SumW'(core.core_sample);

  always_comb begin
    state_d = state_q;
    en_d    = en_q;
    voice_d = voice_q;
    sum_d   = sum_q;
    phase_d = phase_q;
    unique case (state_q)
      StIdle: begin
        if (sample_clk_en) begin
          en_d    = voice_enable;
          sum_d   = '0;
          voice_d = '0;
          state_d = StAdvance;
        end
      end
      StAdvance: begin
        // Muted voices park at zero so key-on always starts from phase 0.
        for (int i = 0; i < int'(NUM_VOICES); i++) begin
          phase_d[i] = en_q[i] ? phase_q[i] + voice_increment[i*ACC_W +: ACC_W] : '0;
        end
        state_d = StDispatch;
      end
      StDispatch: begin
        if (en_q[voice_q]) begin
          state_d = StWait;
        end else if (last_voice) begin
          state_d = StOutput;
        end else begin
          voice_d = voice_q + VoiceW'(1);
        end
      end
      StWait: begin
        if (core.core_done) begin
          sum_d = sum_q + sample_ext;
          if (last_voice) begin
            state_d = StOutput;
          end else begin
            voice_d = voice_q + VoiceW'(1);
            state_d = StDispatch;
          end
        end
      end
      StOutput: state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // core_start is registered but lines up with the DISPATCH cycle of an enabled voice.
  assign start_d = (state_d == StDispatch) && en_q[voice_d];

  always_comb begin
    if (sum_q > SumMax) begin
      sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (sum_q < SumMin) begin
      sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      sat = sum_q[SAMPLE_W-1:0];
    end
  end

  always_ff @(posedge master_clk or negedge rst) begin
    if (!rst) begin
      state_q      <= StIdle;
      en_q         <= '0;
      voice_q      <= '0;
      sum_q        <= '0;
      for (int i = 0; i < int'(NUM_VOICES); i++) phase_q[i] <= '0;
      core_start_q <= 1'b0;
      core_phase_q <= '0;
      mix_output_q <= '0;
      mix_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      en_q         <= en_d;
      voice_q      <= voice_d;
      sum_q        <= sum_d;
      phase_q      <= phase_d;
      core_start_q <= start_d;
      if (start_d) core_phase_q <= phase_d[voice_d];
      mix_valid_q  <= (state_q == StOutput);
      if (state_q == StOutput) mix_output_q <= sat;
      if (sample_clk_en && (state_q != StIdle)) overrun_q <= 1'b1;
      busy_q       <= (state_d != StIdle);
    end
  end

  assign core.core_start = core_start_q;
  assign core.core_phase = core_phase_q;
  assign mix_output      = mix_output_q;
  assign mix_valid       = mix_valid_q;
  assign sample_overrun  = overrun_q;
  assign busy            = busy_q;

endmodule

// File: tb/tb_nco_voice_scheduler.sv
// Directed bench for nco_voice_scheduler with a behavioural NCO core of programmable latency.
module tb_nco_voice_scheduler;
  localparam int unsigned NV = 4;
  localparam int unsigned AW = 32;
  localparam int unsigned SW = 16;

  logic                 master_clk = 1'b0;
  logic                 rst = 1'b0;
  logic                 sample_clk_en = 1'b0;
  logic [NV-1:0]        voice_enable = '0;
  logic [NV*AW-1:0]     voice_increment = '0;
  logic signed [SW-1:0] mix_output;
  logic                 mix_valid;
  logic                 sample_overrun;
  logic                 busy;

  nco_voice_scheduler_if #(.ACC_W(AW), .SAMPLE_W(SW)) core_if ();

  nco_voice_scheduler #(.NUM_VOICES(NV), .ACC_W(AW), .SAMPLE_W(SW)) dut (
    .master_clk      (master_clk),
    .rst             (rst),
    .sample_clk_en   (sample_clk_en),
    .voice_enable    (voice_enable),
    .voice_increment (voice_increment),
    .core            (core_if.master),
    .mix_output      (mix_output),
    .mix_valid       (mix_valid),
    .sample_overrun  (sample_overrun),
    .busy            (busy)
  );

  always #5 master_clk = ~master_clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Core model: returns a sample core_lat cycles after each core_start.
  int                   core_lat = 2;
  bit                   use_phase = 1'b1;
  logic signed [SW-1:0] resp [4];
  int                   n_start = 0;
  logic [AW-1:0]        log_phase [8];
  int                   countdown = 0;
  logic signed [SW-1:0] pend = '0;
  int                   mv_count = 0;

  initial begin
    core_if.core_done   = 1'b0;
    core_if.core_sample = '0;
    forever begin
      @(posedge master_clk); #1;
      core_if.core_done = 1'b0;
      if (!rst) begin
        countdown = 0;
      end else if (core_if.core_start) begin
        if (n_start < 8) log_phase[n_start] = core_if.core_phase;
        pend = use_phase ? core_if.core_phase[AW-1:AW-SW] : resp[n_start % 4];
        n_start++;
        countdown = core_lat;
      end else if (countdown > 0) begin
        countdown--;
        if (countdown == 0) begin
          core_if.core_done   = 1'b1;
          core_if.core_sample = pend;
        end
      end
    end
  end

  initial forever begin
    @(negedge master_clk);
    if (mix_valid) mv_count++;
  end

  task automatic do_reset();
    rst = 1'b0;
    repeat (2) @(posedge master_clk);
    #1;
    rst = 1'b1;
    @(posedge master_clk); #1;
  endtask

  task automatic set_inc(input int v, input logic [AW-1:0] val);
    voice_increment[v*AW +: AW] = val;
  endtask

  // Called just after a clock edge; returns just after the edge that raised mix_valid.
  task automatic run_frame(input string tag, input int exp_lat);
    int lat;
    n_start = 0;
    sample_clk_en = 1'b1;
    @(posedge master_clk); #1;
    sample_clk_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 1000; k++) begin
      if (mix_valid) begin
        lat = k;
        break;
      end
      @(posedge master_clk); #1;
    end
    check_eq({tag, "_latency"}, lat, exp_lat);
  endtask

  initial begin
    int lat;
    resp[0] = '0; resp[1] = '0; resp[2] = '0; resp[3] = '0;
    do_reset();
    check_eq("rst_core_start", core_if.core_start, 0);
    check_eq("rst_core_phase", core_if.core_phase, 0);
    check_eq("rst_mix_output", mix_output, 0);
    check_eq("rst_mix_valid", mix_valid, 0);
    check_eq("rst_overrun", sample_overrun, 0);
    check_eq("rst_busy", busy, 0);

    // All muted: 3 + 4 cycles, no core traffic.
    voice_enable = 4'b0000;
    run_frame("muted", 7);
    check_eq("muted_starts", n_start, 0);
    check_eq("muted_mix", mix_output, 0);

    // Voice 0 alone, sample = phase[31:16].
    voice_enable = 4'b0001;
    set_inc(0, 32'h0100_0000);
    run_frame("v0_f1", 9);
    check_eq("v0_f1_phase", log_phase[0], 32'h0100_0000);
    check_eq("v0_f1_mix", mix_output, 32'h0100);
    run_frame("v0_f2", 9);
    check_eq("v0_f2_phase", log_phase[0], 32'h0200_0000);
    check_eq("v0_f2_mix", mix_output, 32'h0200);

    // Voices 0 and 2, fixed responses.
    do_reset();
    use_phase = 1'b0;
    resp[0] = 16'sd1000; resp[1] = -16'sd300;
    voice_enable = 4'b0101;
    set_inc(0, 32'h0000_1000);
    set_inc(2, 32'h0000_3000);
    run_frame("v02", 11);
    check_eq("v02_starts", n_start, 2);
    check_eq("v02_first_phase", log_phase[0], 32'h0000_1000);
    check_eq("v02_second_phase", log_phase[1], 32'h0000_3000);
    check_eq("v02_mix", mix_output, 700);

    // Saturation both ways.
    do_reset();
    voice_enable = 4'b1111;
    for (int i = 0; i < 4; i++) resp[i] = 16'sd20000;
    run_frame("sat_hi", 15);
    check_eq("sat_hi_mix", mix_output, 32767);
    for (int i = 0; i < 4; i++) resp[i] = -16'sd20000;
    run_frame("sat_lo", 15);
    check_eq("sat_lo_mix", mix_output, -32768);

    // Accumulator wrap, then mute/unmute restarts from zero.
    do_reset();
    use_phase = 1'b1;
    voice_enable = 4'b0001;
    set_inc(0, 32'hF000_0000);
    run_frame("wrap_pre", 9);
    check_eq("wrap_pre_phase", log_phase[0], 32'hF000_0000);
    set_inc(0, 32'h2000_0000);
    run_frame("wrap", 9);
    check_eq("wrap_phase", log_phase[0], 32'h1000_0000);
    check_eq("wrap_mix", mix_output, 32'h1000);
    voice_enable = 4'b0000;
    run_frame("mute", 7);
    check_eq("mute_starts", n_start, 0);
    voice_enable = 4'b0001;
    run_frame("rekey", 9);
    check_eq("rekey_phase", log_phase[0], 32'h2000_0000);

    // Slow core with an overlapping sample_clk_en.
    do_reset();
    core_lat = 200;
    mv_count = 0;
    n_start = 0;
    sample_clk_en = 1'b1;
    @(posedge master_clk); #1;
    sample_clk_en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 1000; k++) begin
      if (mix_valid) begin
        lat = k;
        break;
      end
      sample_clk_en = (k == 20);
      @(posedge master_clk); #1;
    end
    sample_clk_en = 1'b0;
    check_eq("stall_latency", lat, 207);
    check_eq("stall_mix", mix_output, 32'h2000);
    check_eq("stall_overrun", sample_overrun, 1);
    repeat (30) @(posedge master_clk);
    #1;
    check_eq("stall_single_valid", mv_count, 1);
    check_eq("stall_idle", busy, 0);
    check_eq("overrun_sticky", sample_overrun, 1);

    // Reset while waiting on the core.
    n_start = 0;
    sample_clk_en = 1'b1;
    @(posedge master_clk); #1;
    sample_clk_en = 1'b0;
    repeat (10) @(posedge master_clk);
    #1;
    check_eq("midwait_busy", busy, 1);
    check_eq("midwait_phase", core_if.core_phase, 32'h4000_0000);
    rst = 1'b0;
    #2;
    check_eq("arst_core_start", core_if.core_start, 0);
    check_eq("arst_core_phase", core_if.core_phase, 0);
    check_eq("arst_mix_output", mix_output, 0);
    check_eq("arst_mix_valid", mix_valid, 0);
    check_eq("arst_overrun", sample_overrun, 0);
    check_eq("arst_busy", busy, 0);
    repeat (2) @(posedge master_clk);
    #1;
    rst = 1'b1;
    core_lat = 2;
    @(posedge master_clk); #1;
    run_frame("recover", 9);
    check_eq("recover_phase", log_phase[0], 32'h2000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
